// File: rtl/simprisc_lsu_pkg.sv
// Shared types and constants for the simprisc load/store unit.
package simprisc_lsu_pkg;

    localparam int LSU_TIMEOUT_DEFAULT = 16;

    // RISC-V funct3 encodings for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_ILLEGAL  = 2'd3
    } err_code_e;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Only meaningful for already-legal funct3 values.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] ea_lo);
        case (f3[1:0])
            2'b01:   return ea_lo[0];
            2'b10:   return ea_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/simprisc_lsu_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// load lane extraction with sign or zero extension.
module simprisc_lsu_align
    import simprisc_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Byte enables and lane-replicated store data by access width
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << ea_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = ea_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Pick the addressed lane out of the read word and extend it
    always_comb begin
        lane_b    = rdata[7:0];
        lane_h    = ea_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (ea_lo)
            2'b00:   lane_b = rdata[7:0];
            2'b01:   lane_b = rdata[15:8];
            2'b10:   lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        case (funct3)
            F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
            F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
            F3_LBU:  load_data = {24'd0, lane_b};
            F3_LHU:  load_data = {16'd0, lane_h};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/simprisc_lsu.sv
// simprisc load/store unit: one decoded load/store per op, req/ack data
// memory bus, writeback and error strobes.
// Optional build macro SIMPRISC_LSU_MISALIGN_TRAP_EN: trap misaligned
// half/word accesses with err_code 1 instead of silently aligning them.
module simprisc_lsu
    import simprisc_lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1_val,
    input  logic [XLEN-1:0] req_rs2_val,
    input  logic [11:0]     req_imm,
    input  logic [4:0]      req_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            err_valid,
    output logic [1:0]      err_code,
    output logic            busy
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    err_code_e       err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] ea_q, rs2_q, rdata_q, ea_next;
    logic [2:0]      funct3_q;
    logic            is_store_q;
    logic [4:0]      rd_q;
    logic            accept, capture, in_access, bad_align;
    logic [3:0]      al_be;
    logic [31:0]     al_wdata, al_load;

    assign ea_next = req_rs1_val + {{(XLEN-12){req_imm[11]}}, req_imm};

`ifdef SIMPRISC_LSU_MISALIGN_TRAP_EN
    assign bad_align = is_misaligned(req_funct3, ea_next[1:0]);
`else
    assign bad_align = 1'b0;
`endif

    // State, timeout counter and latched operation fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            err_q      <= ERR_NONE;
            cnt_q      <= '0;
            ea_q       <= '0;
            rs2_q      <= '0;
            rdata_q    <= '0;
            funct3_q   <= '0;
            is_store_q <= 1'b0;
            rd_q       <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                ea_q       <= ea_next;
                rs2_q      <= req_rs2_val;
                funct3_q   <= req_funct3;
                is_store_q <= req_is_store;
                rd_q       <= req_rd;
            end
            if (capture) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // Next-state, error classification and capture enables
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                err_d = ERR_NONE;
                cnt_d = '0;
                if (req_valid) begin
                    accept = 1'b1;
                    if (!funct3_legal(req_is_store, req_funct3)) begin
                        state_d = ST_RESP;
                        err_d   = ERR_ILLEGAL;
                    end else if (bad_align) begin
                        state_d = ST_RESP;
                        err_d   = ERR_MISALIGN;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                err_d   = ERR_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = ERR_NONE;
            end
        endcase
    end

    simprisc_lsu_align u_align (
        .funct3     (funct3_q),
        .ea_lo      (ea_q[1:0]),
        .store_data (rs2_q),
        .rdata      (rdata_q),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    assign in_access = (state_q == ST_ACCESS);
    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign busy      = (state_q != ST_IDLE);
    assign mem_req   = in_access;
    assign mem_we    = in_access && is_store_q;
    assign mem_addr  = in_access ? {ea_q[XLEN-1:2], 2'b00} : '0;
    assign mem_be    = in_access ? al_be : 4'b0000;
    assign mem_wdata = (in_access && is_store_q) ? al_wdata : '0;
    assign wb_valid  = (state_q == ST_RESP) && !is_store_q && (err_q == ERR_NONE) && (rd_q != 5'd0);
    assign wb_rd     = wb_valid ? rd_q : 5'd0;
    assign wb_data   = wb_valid ? al_load : '0;
    assign err_valid = (state_q == ST_RESP) && (err_q != ERR_NONE);
    assign err_code  = err_valid ? err_q : ERR_NONE;

endmodule

// File: tb/tb_simprisc_lsu.sv
// Directed bench for simprisc_lsu: table of single-op vectors plus
// hand-written reset sequences.
module tb_simprisc_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1_val, req_rs2_val;
    logic [11:0] req_imm;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, err_valid, busy;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  err_code;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    simprisc_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_rs1_val(req_rs1_val), .req_rs2_val(req_rs2_val),
        .req_imm(req_imm), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_valid(err_valid), .err_code(err_code), .busy(busy)
    );

    typedef struct {
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [11:0] imm;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          ack_at;     // mem_req cycle index that gets ack, -1 = never
        int          exp_req;    // cycles mem_req should stay high
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_wb;
        logic [31:0] exp_wbd;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int    req_cycles = 0;
        int    done_at = -1;
        bit    saw_wb = 0, saw_err = 0;
        logic [31:0] wbd = '0;
        logic [4:0]  wrd = '0;
        logic [1:0]  ec = '0;
        string tag = $sformatf("v%0d", idx);
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_is_store = v.is_store;
        req_funct3   = v.f3;
        req_rs1_val  = v.rs1;
        req_rs2_val  = v.rs2;
        req_imm      = v.imm;
        req_rd       = v.rd;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (req_cycles == 0) begin
                    check({tag, "_addr"}, mem_addr, v.exp_addr);
                    check({tag, "_be"}, {28'd0, mem_be}, {28'd0, v.exp_be});
                    check({tag, "_we"}, {31'd0, mem_we}, {31'd0, v.is_store});
                    if (v.is_store) check({tag, "_wdata"}, mem_wdata, v.exp_wdata);
                end
                if (req_cycles == v.ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
                req_cycles++;
            end
            if (wb_valid) begin
                saw_wb = 1'b1;
                wbd    = wb_data;
                wrd    = wb_rd;
            end
            if (err_valid) begin
                saw_err = 1'b1;
                ec      = err_code;
            end
            if (req_ready) begin
                done_at = c;
                break;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check({tag, "_done_cycle"}, done_at, v.exp_req + 1);
        check({tag, "_req_cycles"}, req_cycles, v.exp_req);
        check({tag, "_wb_valid"}, {31'd0, saw_wb}, {31'd0, v.exp_wb});
        if (v.exp_wb) begin
            check({tag, "_wb_data"}, wbd, v.exp_wbd);
            check({tag, "_wb_rd"}, {27'd0, wrd}, {27'd0, v.rd});
        end
        check({tag, "_err_valid"}, {31'd0, saw_err}, {31'd0, v.exp_err != 2'd0});
        if (v.exp_err != 2'd0) check({tag, "_err_code"}, {30'd0, ec}, {30'd0, v.exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        // is_st f3 rs1 rs2 imm rd rdata ack_at | req addr be wdata wb wbd err
        vecs.push_back('{1'b1, 3'b010, 32'h1000, 32'hDEADBEEF, 12'hFFC, 5'd0, 32'h0, 0,
                         1, 32'h0000_0FFC, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 2'd0});
        vecs.push_back('{1'b0, 3'b000, 32'h2000, 32'h0, 12'h003, 5'd5, 32'h80FF_0000, 0,
                         1, 32'h0000_2000, 4'h8, 32'h0, 1'b1, 32'hFFFF_FF80, 2'd0});
        vecs.push_back('{1'b0, 3'b100, 32'h2000, 32'h0, 12'h003, 5'd6, 32'h80FF_0000, 0,
                         1, 32'h0000_2000, 4'h8, 32'h0, 1'b1, 32'h0000_0080, 2'd0});
        vecs.push_back('{1'b0, 3'b101, 32'h2000, 32'h0, 12'h002, 5'd7, 32'h80FF_0000, 0,
                         1, 32'h0000_2000, 4'hC, 32'h0, 1'b1, 32'h0000_80FF, 2'd0});
        vecs.push_back('{1'b0, 3'b001, 32'h2000, 32'h0, 12'h002, 5'd8, 32'h80FF_0000, 0,
                         1, 32'h0000_2000, 4'hC, 32'h0, 1'b1, 32'hFFFF_80FF, 2'd0});
        vecs.push_back('{1'b1, 3'b000, 32'h0010, 32'h0000_00AB, 12'h001, 5'd0, 32'h0, 0,
                         1, 32'h0000_0010, 4'h2, 32'hABAB_ABAB, 1'b0, 32'h0, 2'd0});
        vecs.push_back('{1'b1, 3'b001, 32'h0020, 32'h0000_1234, 12'h002, 5'd0, 32'h0, 0,
                         1, 32'h0000_0020, 4'hC, 32'h1234_1234, 1'b0, 32'h0, 2'd0});
        vecs.push_back('{1'b0, 3'b010, 32'h3000, 32'h0, 12'h000, 5'd9, 32'hCAFE_F00D, 3,
                         4, 32'h0000_3000, 4'hF, 32'h0, 1'b1, 32'hCAFE_F00D, 2'd0});
        vecs.push_back('{1'b0, 3'b011, 32'h3000, 32'h0, 12'h000, 5'd10, 32'h0, 0,
                         0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 2'd3});
        vecs.push_back('{1'b1, 3'b100, 32'h3000, 32'h1, 12'h000, 5'd0, 32'h0, 0,
                         0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 2'd3});
        vecs.push_back('{1'b0, 3'b010, 32'h0500, 32'h0, 12'h000, 5'd0, 32'h1234_5678, 0,
                         1, 32'h0000_0500, 4'hF, 32'h0, 1'b0, 32'h0, 2'd0});
        vecs.push_back('{1'b0, 3'b010, 32'h0600, 32'h0, 12'h000, 5'd11, 32'h0, -1,
                         16, 32'h0000_0600, 4'hF, 32'h0, 1'b0, 32'h0, 2'd2});
        vecs.push_back('{1'b0, 3'b010, 32'h0700, 32'h0, 12'h000, 5'd12, 32'h0BAD_C0DE, 15,
                         16, 32'h0000_0700, 4'hF, 32'h0, 1'b1, 32'h0BAD_C0DE, 2'd0});
        vecs.push_back('{1'b0, 3'b000, 32'h0, 32'h0, 12'hFFF, 5'd14, 32'h7F00_0000, 0,
                         1, 32'hFFFF_FFFC, 4'h8, 32'h0, 1'b1, 32'h0000_007F, 2'd0});
        vecs.push_back('{1'b1, 3'b010, 32'h0040, 32'h55AA_55AA, 12'h008, 5'd0, 32'h0, 2,
                         3, 32'h0000_0048, 4'hF, 32'h55AA_55AA, 1'b0, 32'h0, 2'd0});
`ifdef SIMPRISC_LSU_MISALIGN_TRAP_EN
        vecs.push_back('{1'b0, 3'b010, 32'h1000, 32'h0, 12'h002, 5'd13, 32'h1122_3344, 0,
                         0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 2'd1});
        vecs.push_back('{1'b0, 3'b001, 32'h2001, 32'h0, 12'h000, 5'd15, 32'h8001_7FFE, 0,
                         0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 2'd1});
`else
        vecs.push_back('{1'b0, 3'b010, 32'h1000, 32'h0, 12'h002, 5'd13, 32'h1122_3344, 0,
                         1, 32'h0000_1000, 4'hF, 32'h0, 1'b1, 32'h1122_3344, 2'd0});
        vecs.push_back('{1'b0, 3'b001, 32'h2001, 32'h0, 12'h000, 5'd15, 32'h8001_7FFE, 0,
                         1, 32'h0000_2000, 4'h3, 32'h0, 1'b1, 32'h0000_7FFE, 2'd0});
`endif

        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
        req_rs1_val = '0; req_rs2_val = '0; req_imm = '0; req_rd = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strobes", {30'd0, wb_valid, err_valid}, 32'd0);
        rst = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check("idle_ack_ignored", {29'd0, busy, wb_valid, err_valid}, 32'd0);
        mem_ack = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset in the middle of an access abandons it without strobes
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
        req_rs1_val = 32'h4000; req_imm = 12'h0; req_rd = 5'd3;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_req_after", {31'd0, mem_req}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (wb_valid || err_valid || mem_req) saw = 1'b1;
        end
        mem_ack = 1'b0;
        check("rst_mid_late_ack_ignored", {31'd0, saw}, 32'd0);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);

        // A normal op still works after the abandoned one
        run_vec(99, '{1'b0, 3'b010, 32'h0800, 32'h0, 12'h004, 5'd4, 32'hA5A5_0F0F, 0,
                       1, 32'h0000_0804, 4'hF, 32'h0, 1'b1, 32'hA5A5_0F0F, 2'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
